// File: rtl/brpred.sv
// brpred: direct-mapped BTB with 2-bit saturating counters, mispredict detection and stats
module brpred #(
  parameter int INDEX_W = 4
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic [31:0] pc_f_i,
  output logic        pred_taken_o,
  output logic [31:0] pred_target_o,
  input  logic        ex_valid_i,
  input  logic        ex_is_br_i,
  input  logic        ex_is_jmp_i,
  input  logic [31:0] ex_pc_i,
  input  logic        ex_taken_i,
  input  logic [31:0] ex_target_i,
  input  logic        ex_pred_taken_i,
  input  logic [31:0] ex_pred_target_i,
  output logic        mispredict_o,
  output logic [31:0] redirect_pc_o,
  output logic [31:0] br_cnt_o,
  output logic [31:0] miss_cnt_o
);
  localparam int N  = 1 << INDEX_W;
  localparam int TW = 30 - INDEX_W;

  logic [N-1:0]    valid_q;
  logic [TW-1:0]   tag_q [N];
  logic [31:0]     tgt_q [N];
  logic [1:0]      cnt_q [N];
  logic [31:0]     br_cnt_q, br_cnt_d, miss_cnt_q, miss_cnt_d;

  logic [INDEX_W-1:0] fi, ei;
  logic [TW-1:0]      ftag, etag;
  logic               f_hit, e_hit, res, act_taken;
  logic               we_d, v_d;
  logic [31:0]        tgt_d;
  logic [1:0]         cnt_d;
  logic               unused_ok;

  assign unused_ok = ^{pc_f_i[1:0], ex_pc_i[1:0]};

  assign fi    = pc_f_i[INDEX_W+1:2];
  assign ftag  = pc_f_i[31:INDEX_W+2];
  assign ei    = ex_pc_i[INDEX_W+1:2];
  assign etag  = ex_pc_i[31:INDEX_W+2];
  assign f_hit = valid_q[fi] && (tag_q[fi] == ftag);
  assign e_hit = valid_q[ei] && (tag_q[ei] == etag);

  assign pred_taken_o  = f_hit && cnt_q[fi][1];
  assign pred_target_o = pred_taken_o ? tgt_q[fi] : pc_f_i + 32'd4;

  // jumps are taken no matter what the branch unit reports
  assign res           = ex_is_br_i || ex_is_jmp_i;
  assign act_taken     = ex_is_jmp_i || (ex_is_br_i && ex_taken_i);
  assign mispredict_o  = ex_valid_i && (res ? ((act_taken != ex_pred_taken_i) ||
                         (act_taken && (ex_target_i != ex_pred_target_i))) : ex_pred_taken_i);
  assign redirect_pc_o = act_taken ? ex_target_i : ex_pc_i + 32'd4;

  assign br_cnt_d   = br_cnt_q + {31'd0, ex_valid_i && res};
  assign miss_cnt_d = miss_cnt_q + {31'd0, mispredict_o};
  assign br_cnt_o   = br_cnt_q;
  assign miss_cnt_o = miss_cnt_q;

  always_comb begin
    we_d  = 1'b0;
    v_d   = 1'b0;
    tgt_d = tgt_q[ei];
    cnt_d = cnt_q[ei];
    if (ex_valid_i) begin
      if (ex_is_jmp_i) begin
        we_d  = 1'b1;
        v_d   = 1'b1;
        tgt_d = ex_target_i;
        cnt_d = 2'd3;
      end else if (ex_is_br_i && e_hit) begin
        we_d  = 1'b1;
        v_d   = 1'b1;
        tgt_d = ex_taken_i ? ex_target_i : tgt_q[ei];
        cnt_d = ex_taken_i ? ((cnt_q[ei] == 2'd3) ? 2'd3 : cnt_q[ei] + 2'd1)
                           : ((cnt_q[ei] == 2'd0) ? 2'd0 : cnt_q[ei] - 2'd1);
      end else if (ex_is_br_i && ex_taken_i) begin
        we_d  = 1'b1;
        v_d   = 1'b1;
        tgt_d = ex_target_i;
        cnt_d = 2'd2;
      end else if (!res && ex_pred_taken_i && e_hit) begin
        we_d  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q    <= '0;
      br_cnt_q   <= '0;
      miss_cnt_q <= '0;
      for (int i = 0; i < N; i++) cnt_q[i] <= 2'd1;
    end else begin
      br_cnt_q   <= br_cnt_d;
      miss_cnt_q <= miss_cnt_d;
      if (we_d) begin
        valid_q[ei] <= v_d;
        cnt_q[ei]   <= cnt_d;
      end
    end
  end

  // tag and target are qualified by valid, so they need no reset
  always_ff @(posedge clk_i) begin
    if (rst_ni && we_d) begin
      tag_q[ei] <= etag;
      tgt_q[ei] <= tgt_d;
    end
  end
endmodule

// File: doc/brpred.md
# brpred

Branch predictor for the fetch stage: a direct-mapped branch target buffer with a 2-bit saturating counter per entry. It predicts taken/not-taken and the target for the PC being fetched, and is trained by the execute-stage branch resolution, the other end of the branch unit's taken/not-taken decision. It also raises the mispredict and redirect signals that steer the PC mux and flush the front end.

## Interface
- `INDEX_W`, default 4: entry count is 2^INDEX_W; index = pc[INDEX_W+1:2], tag = pc[31:INDEX_W+2].
- `clk_i`, input, 1: clock, rising edge.
- `rst_ni`, input, 1: reset, asynchronous, active-low.
- `pc_f_i`, input, 32: fetch-stage PC.
- `pred_taken_o`, output, 1: prediction for `pc_f_i` (1 = taken).
- `pred_target_o`, output, 32: predicted target; equals `pc_f_i`+4 when `pred_taken_o`=0.
- `ex_valid_i`, input, 1: the execute stage holds a valid instruction this cycle.
- `ex_is_br_i`, input, 1: the execute instruction is a B-type branch.
- `ex_is_jmp_i`, input, 1: the execute instruction is JAL or JALR.
- `ex_pc_i`, input, 32: PC of the execute instruction.
- `ex_taken_i`, input, 1: resolved outcome (1 = taken). This is the inverse of the branch unit's PC-mux select.
- `ex_target_i`, input, 32: resolved target from the ALU.
- `ex_pred_taken_i`, input, 1: prediction made at fetch, carried down the pipeline.
- `ex_pred_target_i`, input, 32: target predicted at fetch, carried down the pipeline.
- `mispredict_o`, output, 1: front-end flush request.
- `redirect_pc_o`, output, 32: correct next PC when `mispredict_o`=1.
- `br_cnt_o`, output, 32: number of resolved branches and jumps.
- `miss_cnt_o`, output, 32: number of mispredicts.

## Operation
**Entry contents:** valid bit, tag, 32-bit target, 2-bit counter.
- Counter values: 0 strong-NT, 1 weak-NT, 2 weak-T, 3 strong-T.

**Lookup (combinational on registered table):**
- Hit = valid and tag match.
- `pred_taken_o` = hit and counter[1].
- `pred_target_o` = stored target on a predicted-taken hit, else `pc_f_i`+4 (modulo 2^32).

**Resolve:** active when `ex_valid_i`=1. Let `res` = `ex_is_br_i` or `ex_is_jmp_i`.
- A jump is always taken, regardless of `ex_taken_i`.
- `mispredict_o`=1 when `res`=1 and either:
  - the taken outcome differs from `ex_pred_taken_i`, or
  - the instruction is taken and `ex_target_i` != `ex_pred_target_i`.
- `mispredict_o`=1 also when `res`=0 and `ex_pred_taken_i`=1 (stale or aliased entry).
- `redirect_pc_o` = `ex_target_i` when the instruction is actually taken, else `ex_pc_i`+4.

**Update on the clock edge, indexed by `ex_pc_i`:**
- Branch, hit:
  - target ← `ex_target_i` if taken.
  - counter +1 on taken (saturates at 3), −1 on not taken (saturates at 0).
- Branch, miss, taken: allocate the entry (overwrites any occupant). valid=1, tag, target, counter=2.
- Branch, miss, not taken: no write.
- Jump: allocate or overwrite with counter=3 and target=`ex_target_i`.
- `res`=0 with `ex_pred_taken_i`=1: clear valid at that index if the tag matches.
- `ex_valid_i`=0: no table or statistics change.

**Statistics:**
- `br_cnt_o` += 1 per cycle with `ex_valid_i` and `res`.
- `miss_cnt_o` += 1 per cycle with `mispredict_o`.
- Both wrap at 2^32.

## Timing
- Reset (asynchronous, active-low):
  - All valid bits = 0 and all counters = 1.
  - `br_cnt_o`=0 and `miss_cnt_o`=0.
  - `pred_taken_o`=0 and `pred_target_o`=`pc_f_i`+4.
  - `mispredict_o`=0 once the execute inputs are idle; it is combinational.
- Assertion mid-operation clears the table immediately and discards any pending update.
- Prediction has zero latency: same cycle as `pc_f_i`.
- `mispredict_o` and `redirect_pc_o` are combinational, in the same cycle as the execute inputs.
- A table update is visible to lookup from the cycle after the resolving edge.
- Lookup and update to the same index in the same cycle: lookup returns the pre-update contents. There is no bypass.
- Back-to-back resolves in consecutive cycles each update independently; counters saturate and never wrap.
- Targets and PC+4 use 32-bit modulo arithmetic: `pc_f_i`=0xFFFFFFFC gives 0x00000000.

## Test plan
- **Reset:** hold `rst_ni`=0 with `pc_f_i`=0x100 → `pred_taken_o`=0, `pred_target_o`=0x104, both counters 0.
- **Allocation:** resolve branch at 0x40 taken to 0x80 with pred=0 → `mispredict_o`=1, `redirect_pc_o`=0x80. Next cycle `pc_f_i`=0x40 → `pred_taken_o`=1, `pred_target_o`=0x80.
- **Hysteresis:** from counter=2, resolve 0x40 not taken (pred=1) → mispredict, redirect 0x44, counter=1, fetch predicts NT. Resolve taken twice → counter=3, then one NT keeps the prediction taken.
- **Aliasing:** 0x40 is allocated; resolve taken at 0x440 (same index, different tag) → entry overwritten. `pc_f_i`=0x40 then misses and predicts 0x44.
- **Jump and stale entry:** JAL at 0x10 to 0x200 allocates with counter=3. Then `ex_is_br_i`=0, `ex_is_jmp_i`=0 at 0x10 with pred=1 → mispredict, redirect 0x14, entry invalidated.
- **Counters:** 5 branch resolves with 2 mispredicts, plus cycles with `ex_valid_i`=0 → `br_cnt_o`=5, `miss_cnt_o`=2. Same-cycle lookup of the index being updated returns the old prediction.
